// File: rtl/fft_pkg.sv
// Shared definitions for the FFT stage counter: FSM state type and default widths.
package fft_pkg;

  localparam int FFT_CNT_W   = 12;
  localparam int FFT_STAGE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fft_state_e;

endpackage

// File: rtl/fft_bitrev.sv
// Purely combinational bit reversal: out[i] = in[WIDTH-1-i].
module fft_bitrev #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rev
      assign out_o[gi] = in_i[WIDTH-1-gi];
    end
  endgenerate

endmodule

// File: rtl/fft_stage_counter.sv
// Sample-index / stage counter for FFT sequencing (IDLE -> RUN -> DONE).
// Optional bit-reversed index output enabled by defining FFT_CNT_BITREV_EN.
module fft_stage_counter
  import fft_pkg::*;
#(
  parameter int WIDTH   = FFT_CNT_W,
  parameter int STAGE_W = FFT_STAGE_W
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               ce,
  input  logic               clr,
  input  logic               start,
  input  logic               dir,
  input  logic [WIDTH-1:0]   max_val,
  input  logic [STAGE_W-1:0] max_stage,
  output logic [WIDTH-1:0]   o_data,
  output logic [STAGE_W-1:0] o_stage,
`ifdef FFT_CNT_BITREV_EN
  output logic [WIDTH-1:0]   o_bitrev,
`endif
  output logic               over,
  output logic               last,
  output logic               busy,
  output logic               done
);

  fft_state_e         state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [WIDTH-1:0]   max_val_q, max_val_d;
  logic [STAGE_W-1:0] max_stage_q, max_stage_d;
  logic               dir_q, dir_d;
  logic               busy_q, done_q;

  logic [WIDTH-1:0] terminal;
  logic [WIDTH-1:0] start_val;
  logic             at_term;

  // Down-counting starts at max_val and terminates at 0; up-counting the reverse.
  assign terminal  = dir_q ? '0 : max_val_q;
  assign start_val = dir_q ? max_val_q : '0;
  assign at_term   = (data_q == terminal);

  assign over = (state_q == RUN) && ce && at_term;
  assign last = over && (stage_q == max_stage_q);

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    stage_d     = stage_q;
    max_val_d   = max_val_q;
    max_stage_d = max_stage_q;
    dir_d       = dir_q;
    if (clr) begin
      state_d = IDLE;
      data_d  = '0;
      stage_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            max_val_d   = max_val;
            max_stage_d = max_stage;
            dir_d       = dir;
            data_d      = dir ? max_val : '0;
            stage_d     = '0;
            state_d     = RUN;
          end
        end
        RUN: begin
          if (ce) begin
            if (!at_term) begin
              data_d = dir_q ? (data_q - WIDTH'(1)) : (data_q + WIDTH'(1));
            end else begin
              data_d = start_val;
              if (stage_q < max_stage_q) begin
                stage_d = stage_q + STAGE_W'(1);
              end else begin
                state_d = DONE;
              end
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      stage_q     <= '0;
      max_val_q   <= '0;
      max_stage_q <= '0;
      dir_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      stage_q     <= stage_d;
      max_val_q   <= max_val_d;
      max_stage_q <= max_stage_d;
      dir_q       <= dir_d;
      busy_q      <= (state_d == RUN);
      done_q      <= (state_d == DONE);
    end
  end

  assign o_data  = data_q;
  assign o_stage = stage_q;
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef FFT_CNT_BITREV_EN
  fft_bitrev #(.WIDTH(WIDTH)) u_bitrev (
    .in_i  (data_q),
    .out_o (o_bitrev)
  );
`endif

endmodule

// File: tb/tb_fft_stage_counter.sv
// Directed self-checking bench for fft_stage_counter (WIDTH=12, STAGE_W=4).
module tb_fft_stage_counter;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        ce = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        dir = 1'b0;
  logic [11:0] max_val = '0;
  logic [3:0]  max_stage = '0;
  logic [11:0] o_data;
  logic [3:0]  o_stage;
  logic        over, last, busy, done;
`ifdef FFT_CNT_BITREV_EN
  logic [11:0] o_bitrev;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fft_stage_counter #(.WIDTH(12), .STAGE_W(4)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .ce        (ce),
    .clr       (clr),
    .start     (start),
    .dir       (dir),
    .max_val   (max_val),
    .max_stage (max_stage),
    .o_data    (o_data),
    .o_stage   (o_stage),
`ifdef FFT_CNT_BITREV_EN
    .o_bitrev  (o_bitrev),
`endif
    .over      (over),
    .last      (last),
    .busy      (busy),
    .done      (done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Status vector layout: {busy, done, over, last, o_data[11:0], o_stage[3:0]}
  task automatic test_reset;
    logic [19:0] exp_v;
    nrst = 1'b0; ce = 1'b1; start = 1'b1; max_val = 12'd5;
    #2;
    exp_v = {4'b0000, 12'd0, 4'd0};
    n_checks++;
    if ({busy, done, over, last, o_data, o_stage} !== exp_v)
      $display("FAIL reset_async: got %h expected %h", {busy, done, over, last, o_data, o_stage}, exp_v);
    if ({busy, done, over, last, o_data, o_stage} !== exp_v) n_errors++;
    tick;
    n_checks++;
    if ({busy, done, over, last, o_data, o_stage} !== exp_v) begin
      n_errors++;
      $display("FAIL reset_held: got %h expected %h", {busy, done, over, last, o_data, o_stage}, exp_v);
    end
    start = 1'b0;
    #2 nrst = 1'b1;
    tick;
    n_checks++;
    if ({busy, done, o_data, o_stage} !== 18'd0) begin
      n_errors++;
      $display("FAIL reset_idle: got %h expected 0", {busy, done, o_data, o_stage});
    end
  endtask

  task automatic test_up_count;
    logic [19:0] exp_v;
    start = 1'b1; dir = 1'b0; max_val = 12'd3; max_stage = 4'd1; ce = 1'b1;
    tick;
    // Changing the live config must not disturb the captured run.
    start = 1'b0; max_val = 12'd9; dir = 1'b1; max_stage = 4'd5;
    for (int i = 0; i < 8; i++) begin
      exp_v = {1'b1, 1'b0, (i % 4) == 3, i == 7, 12'(i % 4), 4'(i / 4)};
      n_checks++;
      if ({busy, done, over, last, o_data, o_stage} !== exp_v) begin
        n_errors++;
        $display("FAIL up_count[%0d]: got %h expected %h", i, {busy, done, over, last, o_data, o_stage}, exp_v);
      end
      tick;
    end
    n_checks++;
    if ({busy, done, over, last, o_stage} !== {4'b0100, 4'd1}) begin
      n_errors++;
      $display("FAIL up_done: got %h expected %h", {busy, done, over, last, o_stage}, {4'b0100, 4'd1});
    end
    tick;
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_errors++;
      $display("FAIL up_done_width: busy/done got %b expected 00", {busy, done});
    end
  endtask

  task automatic test_down_count;
    logic [19:0] exp_v;
    start = 1'b1; dir = 1'b1; max_val = 12'd4; max_stage = 4'd0; ce = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_v = {1'b1, 1'b0, i == 4, i == 4, 12'(4 - i), 4'd0};
      n_checks++;
      if ({busy, done, over, last, o_data, o_stage} !== exp_v) begin
        n_errors++;
        $display("FAIL down_count[%0d]: got %h expected %h", i, {busy, done, over, last, o_data, o_stage}, exp_v);
      end
`ifdef FFT_CNT_BITREV_EN
      if (i == 2) begin
        n_checks++;
        if (o_bitrev !== 12'h400) begin
          n_errors++;
          $display("FAIL bitrev: got %h expected 400", o_bitrev);
        end
      end
`endif
      tick;
    end
    n_checks++;
    if ({busy, done} !== 2'b01) begin
      n_errors++;
      $display("FAIL down_done: busy/done got %b expected 01", {busy, done});
    end
    tick;
  endtask

  task automatic test_stall;
    int          ce_pat[5]   = '{1, 0, 1, 0, 1};
    int          data_pat[5] = '{0, 1, 1, 2, 2};
    logic [19:0] exp_v;
    start = 1'b1; dir = 1'b0; max_val = 12'd2; max_stage = 4'd0; ce = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ce = ce_pat[i][0];
      #1;
      exp_v = {1'b1, 1'b0, i == 4, i == 4, 12'(data_pat[i]), 4'd0};
      n_checks++;
      if ({busy, done, over, last, o_data, o_stage} !== exp_v) begin
        n_errors++;
        $display("FAIL stall[%0d]: got %h expected %h", i, {busy, done, over, last, o_data, o_stage}, exp_v);
      end
      tick;
    end
    ce = 1'b1;
    n_checks++;
    if ({busy, done} !== 2'b01) begin
      n_errors++;
      $display("FAIL stall_done: busy/done got %b expected 01", {busy, done});
    end
    tick;
  endtask

  task automatic test_abort;
    start = 1'b1; clr = 1'b1; dir = 1'b0; max_val = 12'd10; max_stage = 4'd0; ce = 1'b1;
    tick;
    n_checks++;
    if ({busy, done, o_data} !== 14'd0) begin
      n_errors++;
      $display("FAIL abort_idle_clr: got %h expected 0", {busy, done, o_data});
    end
    clr = 1'b0;
    tick;
    start = 1'b0;
    repeat (5) tick;
    n_checks++;
    if ({busy, o_data} !== {1'b1, 12'd5}) begin
      n_errors++;
      $display("FAIL abort_pre: got %h expected %h", {busy, o_data}, {1'b1, 12'd5});
    end
    clr = 1'b1;
    tick;
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({busy, done, o_data, o_stage} !== 18'd0) begin
        n_errors++;
        $display("FAIL abort_post[%0d]: got %h expected 0", i, {busy, done, o_data, o_stage});
      end
      tick;
    end
  endtask

  task automatic test_reset_restart;
    logic [19:0] exp_v;
    start = 1'b1; dir = 1'b0; max_val = 12'd8; max_stage = 4'd0; ce = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    #3 nrst = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, over, o_data, o_stage} !== 19'd0) begin
      n_errors++;
      $display("FAIL reset_midrun: got %h expected 0", {busy, done, over, o_data, o_stage});
    end
    #1 nrst = 1'b1;
    start = 1'b1; max_val = 12'd0; max_stage = 4'd2;
    tick;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_v = {1'b1, 1'b0, 1'b1, i == 2, 12'd0, 4'(i)};
      n_checks++;
      if ({busy, done, over, last, o_data, o_stage} !== exp_v) begin
        n_errors++;
        $display("FAIL restart[%0d]: got %h expected %h", i, {busy, done, over, last, o_data, o_stage}, exp_v);
      end
      tick;
    end
    n_checks++;
    if ({busy, done, o_stage} !== {2'b01, 4'd2}) begin
      n_errors++;
      $display("FAIL restart_done: got %h expected %h", {busy, done, o_stage}, {2'b01, 4'd2});
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_up_count;
    test_down_count;
    test_stall;
    test_abort;
    test_reset_restart;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fft_stage_counter.md
FFT_STAGE_COUNTER -- requirements
Module: fft_stage_counter

Interface
REQ-001 Parameter WIDTH, default 12: width of the sample index counter and max_val.
REQ-002 Parameter STAGE_W, default 4: width of the stage counter and max_stage.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port nrst, input, 1: asynchronous active-low reset.
REQ-005 Port ce, input, 1: count enable; when low, all counter state holds.
REQ-006 Port clr, input, 1: synchronous abort back to IDLE.
REQ-007 Port start, input, 1: launch request; sampled only in IDLE.
REQ-008 Port dir, input, 1: direction; 0 counts up 0..max_val, 1 counts down max_val..0.
REQ-009 Port max_val, input, WIDTH: terminal sample index, captured at start.
REQ-010 Port max_stage, input, STAGE_W: last stage index, captured at start.
REQ-011 Port o_data, output, WIDTH: current sample index (registered).
REQ-012 Port o_stage, output, STAGE_W: current stage index (registered).
REQ-013 Port o_bitrev, output, WIDTH: o_data bit-reversed across all WIDTH bits; present only with FFT_CNT_BITREV_EN.
REQ-014 Port over, output, 1: combinational; high on a counting cycle at the sample terminal.
REQ-015 Port last, output, 1: combinational; over AND o_stage equals captured max_stage.
REQ-016 Port busy, output, 1: registered; high in RUN.
REQ-017 Port done, output, 1: registered; high for exactly one cycle in DONE.

Function
REQ-018 FSM states: IDLE, RUN, DONE. There are no other reachable states.
REQ-019 IDLE with start=1 and clr=0: capture max_val, max_stage and dir; load o_data (0 if up, max_val if down); load o_stage=0; next state RUN.
REQ-020 RUN with ce=1: if o_data is not at terminal (max_val up, 0 down), step by +1/-1 on the next edge.
REQ-021 RUN with ce=1 and o_data at terminal: reload start value; if o_stage < captured max_stage, increment o_stage; otherwise go to DONE with o_stage held.
REQ-022 over SHALL equal (state==RUN) AND ce AND (o_data==terminal); it is 0 in IDLE and DONE.
REQ-023 DONE SHALL last one cycle, then return to IDLE; o_data and o_stage hold their final values until the next start.
REQ-024 clr=1 in any state: next state IDLE and o_data=o_stage=0. clr has priority over start and ce.
REQ-025 start is ignored in RUN and DONE. Input changes during RUN have no effect, because configuration is captured at start.
REQ-026 max_val=0: over is asserted on every ce cycle in RUN; each stage lasts one ce cycle.
REQ-027 max_stage=0: a single pass; last coincides with the first over.
REQ-028 Arithmetic is unsigned modulo 2^WIDTH. The terminal compare uses equality, so no wrap past max_val occurs.
REQ-029 Latency from start to first valid index is 1 cycle: busy=1 and o_data holds the start value on the edge after start.

Reset
REQ-030 nrst=0 SHALL asynchronously force state IDLE, o_data=0, o_stage=0, busy=0, done=0 and all captured registers to 0.
REQ-031 Reset mid-RUN aborts immediately; no done pulse is produced.
REQ-032 The first start is accepted on the first rising edge after nrst deasserts.

Configuration
REQ-033 Macro FFT_CNT_BITREV_EN defined: o_bitrev port and bit-reverse logic are present; o_bitrev follows o_data combinationally.
REQ-034 Macro FFT_CNT_BITREV_EN undefined: o_bitrev port is absent; all other behaviour is identical.

Structure
REQ-035 Shared package fft_pkg SHALL hold the state enum typedef (IDLE/RUN/DONE) and default constants FFT_CNT_W=12 and FFT_STAGE_W=4.
REQ-036 Bit reversal SHALL be a sub-module fft_bitrev (parameter WIDTH, purely combinational), instantiated only under FFT_CNT_BITREV_EN.

Verification (WIDTH=12, STAGE_W=4)
REQ-037 Up-count scenario: start, dir=0, max_val=3, max_stage=1, ce=1 continuously.
- Required response: o_data 0,1,2,3,0,1,2,3.
- over at both 3s; last at the second 3; done 1 cycle later; total 9 cycles.
REQ-038 Down-count scenario: dir=1, max_val=4, max_stage=0.
- Required response: o_data 4,3,2,1,0; over and last at 0; o_bitrev=0x400 when o_data=2 (macro on).
REQ-039 Stall scenario: ce toggled 1,0,1,0 with max_val=2.
- Required response: o_data changes only on ce=1 edges; over is never high with ce=0.
REQ-040 Abort scenario: clr with start in IDLE, then clr mid-RUN at o_data=5.
- Required response: IDLE next cycle, o_data=0, busy=0, no done pulse.
REQ-041 Reset scenario: nrst pulsed low asynchronously between edges mid-RUN.
- Required response: outputs zero immediately; restart with max_val=0, max_stage=2 gives over on 3 consecutive ce cycles, then done.
